// File: rtl/branch_ctrl.sv
// Branch/condition controller: captures compare result codes, resolves
// conditional branches against a programmed mask and drives the fetch PC.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef PORT_BRANCH_TARGET
`define PORT_BRANCH_TARGET 8'h30
`endif
`ifndef PORT_BRANCH_COND
`define PORT_BRANCH_COND 8'h31
`endif
`ifndef PORT_BRANCH_STATUS
`define PORT_BRANCH_STATUS 8'h32
`endif

module branch_ctrl #(
  parameter int DATA_WIDTH   = `DATA_WIDTH,
  parameter int PC_WIDTH     = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] i_port,
  input  logic [DATA_WIDTH-1:0] i_cmp_result,
  input  logic                  i_stall,
  output logic [PC_WIDTH-1:0]   o_pc,
  output logic                  o_taken,
  output logic                  o_flush,
  output logic [DATA_WIDTH-1:0] o_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [3:0]          flush_cnt, flush_cnt_nx;
  logic [2:0]          flags;
  logic [3:0]          mask;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] pc;

  logic port_tgt, port_cond, port_stat;
  logic taken, cond_accept, load_pc;

  always_comb begin
    port_tgt  = (i_port == DATA_WIDTH'(`PORT_BRANCH_TARGET));
    port_cond = (i_port == DATA_WIDTH'(`PORT_BRANCH_COND));
    port_stat = (i_port == DATA_WIDTH'(`PORT_BRANCH_STATUS));
  end

  // mask bit3 forces the branch; low bits select which flags qualify
  always_comb begin
    taken = mask[3] | (|(mask[2:0] & flags));
  end

  always_comb begin
    state_nx     = state;
    flush_cnt_nx = flush_cnt;
    cond_accept  = 1'b0;
    load_pc      = 1'b0;
    case (state)
      IDLE: begin
        if (port_cond) begin
          cond_accept = 1'b1;
          state_nx    = EVAL;
        end
      end
      EVAL: begin
        if (taken) begin
          load_pc      = 1'b1;
          flush_cnt_nx = 4'(FLUSH_CYCLES);
          state_nx     = FLUSH;
        end else begin
          state_nx = IDLE;
        end
      end
      FLUSH: begin
        flush_cnt_nx = flush_cnt - 4'd1;
        if (flush_cnt <= 4'd1) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx     = IDLE;
        flush_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nx;
      flush_cnt <= flush_cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else begin
      if (i_cmp_result == DATA_WIDTH'(1)) begin
        flags <= 3'b001;
      end else if (i_cmp_result == DATA_WIDTH'(2)) begin
        flags <= 3'b010;
      end else if (i_cmp_result == DATA_WIDTH'(3)) begin
        flags <= 3'b100;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target <= '0;
      mask   <= '0;
    end else begin
      if (port_tgt) begin
        target <= i_data[PC_WIDTH-1:0];
      end
      if (cond_accept) begin
        mask <= i_data[3:0];
      end
    end
  end

  // Taken load wins over stall; otherwise the PC free-runs and wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (load_pc) begin
      pc <= target;
    end else if (!i_stall) begin
      pc <= pc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_taken <= 1'b0;
      o_data  <= '0;
    end else begin
      o_taken <= load_pc;
      o_data  <= port_stat ? DATA_WIDTH'({state, flags}) : '0;
    end
  end

  assign o_pc    = pc;
  assign o_flush = (state == FLUSH);

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef PORT_BRANCH_TARGET
`define PORT_BRANCH_TARGET 8'h30
`endif
`ifndef PORT_BRANCH_COND
`define PORT_BRANCH_COND 8'h31
`endif
`ifndef PORT_BRANCH_STATUS
`define PORT_BRANCH_STATUS 8'h32
`endif

module tb_branch_ctrl;
  localparam int DW = 8;
  localparam int PW = 8;
  localparam int FC = 2;
  localparam logic [7:0] P_TGT  = `PORT_BRANCH_TARGET;
  localparam logic [7:0] P_COND = `PORT_BRANCH_COND;
  localparam logic [7:0] P_STAT = `PORT_BRANCH_STATUS;

  logic          clk;
  logic          rst = 1'b1;
  logic [DW-1:0] i_data = '0;
  logic [DW-1:0] i_port = '0;
  logic [DW-1:0] i_cmp_result = '0;
  logic          i_stall = 1'b0;
  logic [PW-1:0] o_pc;
  logic          o_taken;
  logic          o_flush;
  logic [DW-1:0] o_data;

  int checks = 0;
  int errors = 0;
  bit run_check = 1'b0;

  branch_ctrl #(
    .DATA_WIDTH  (DW),
    .PC_WIDTH    (PW),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_data      (i_data),
    .i_port      (i_port),
    .i_cmp_result(i_cmp_result),
    .i_stall     (i_stall),
    .o_pc        (o_pc),
    .o_taken     (o_taken),
    .o_flush     (o_flush),
    .o_data      (o_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: branch in progress is "eval pending" or a count of
  // flush cycles still owed; everything else is plain arithmetic.
  int unsigned m_pc, m_target, m_data;
  bit [2:0]    m_flags;
  bit [3:0]    m_mask;
  bit          m_eval, m_taken, decide;
  int          m_flush_left, st;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 0; m_target = 0; m_data = 0; m_flags = 0; m_mask = 0;
      m_eval = 0; m_taken = 0; m_flush_left = 0;
    end else begin
      st     = m_eval ? 1 : (m_flush_left > 0 ? 2 : 0);
      decide = m_mask[3] || ((m_mask[2:0] & m_flags) != 3'b000);
      m_data = (i_port == P_STAT) ? (st * 8 + int'(m_flags)) : 0;
      m_taken = 0;
      if (m_eval) begin
        m_eval = 0;
        if (decide) begin
          m_pc = m_target;
          m_taken = 1;
          m_flush_left = FC;
        end else if (!i_stall) begin
          m_pc = (m_pc + 1) % (1 << PW);
        end
      end else begin
        if (m_flush_left > 0) m_flush_left--;
        else if (i_port == P_COND) begin
          m_mask = i_data[3:0];
          m_eval = 1;
        end
        if (!i_stall) m_pc = (m_pc + 1) % (1 << PW);
      end
      if (i_port == P_TGT) m_target = i_data;
      case (i_cmp_result)
        8'd1: m_flags = 3'b001;
        8'd2: m_flags = 3'b010;
        8'd3: m_flags = 3'b100;
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    #3;
    if (run_check) begin
      chk("pc", 32'(o_pc), 32'(m_pc));
      chk("taken", 32'(o_taken), 32'(m_taken));
      chk("flush", 32'(o_flush), 32'(m_flush_left > 0));
      chk("data", 32'(o_data), 32'(m_data));
    end
  end

  task automatic drive(input logic [7:0] d, input logic [7:0] p, input logic [7:0] c,
                       input logic s);
    @(negedge clk);
    i_data = d; i_port = p; i_cmp_result = c; i_stall = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_data = '0; i_port = '0; i_cmp_result = '0; i_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    run_check = 1'b1;
    chk("reset_pc", 32'(o_pc), 32'h0);
    chk("reset_flush", 32'(o_flush), 32'h0);
    chk("reset_data", 32'(o_data), 32'h0);

    // free-running PC and wrap
    for (int i = 1; i <= 300; i++) begin
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      if (i == 255) chk("pc_255", 32'(o_pc), 32'hff);
      if (i == 256) chk("pc_wrap", 32'(o_pc), 32'h00);
      if (i == 300) chk("pc_300", 32'(o_pc), 32'd44);
    end

    // lt-taken branch to 0x40
    drive(8'h40, P_TGT, 8'h02, 1'b0);
    drive(8'h02, P_COND, 8'h00, 1'b0);
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    chk("t2_taken", 32'(o_taken), 32'h1);
    chk("t2_pc", 32'(o_pc), 32'h40);
    chk("t2_flush0", 32'(o_flush), 32'h1);
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    chk("t2_taken_pulse", 32'(o_taken), 32'h0);
    chk("t2_flush1", 32'(o_flush), 32'h1);
    chk("t2_pc_inc", 32'(o_pc), 32'h41);
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    chk("t2_flush_end", 32'(o_flush), 32'h0);

    // gt flags vs eq|lt mask: not taken, status shows EVAL then IDLE
    drive(8'h00, 8'h00, 8'h01, 1'b0);
    drive(8'h06, P_COND, 8'h00, 1'b0);
    drive(8'h00, P_STAT, 8'h00, 1'b0);
    drive(8'h00, P_STAT, 8'h00, 1'b0);
    chk("t3_status_eval", 32'(o_data), 32'h09);
    chk("t3_not_taken", 32'(o_taken), 32'h0);
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    chk("t3_status_idle", 32'(o_data), 32'h01);
    chk("t3_no_flush", 32'(o_flush), 32'h0);

    // eq result in the same cycle as the condition write; squashed rewrite
    drive(8'h80, P_TGT, 8'h00, 1'b0);
    drive(8'h04, P_COND, 8'h03, 1'b0);
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    drive(8'h08, P_COND, 8'h00, 1'b0);
    chk("t4_taken", 32'(o_taken), 32'h1);
    chk("t4_pc", 32'(o_pc), 32'h80);
    for (int i = 0; i < 4; i++) begin
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      chk("t4_no_second_taken", 32'(o_taken), 32'h0);
    end

    // always-taken with zero flags under stall
    do_reset();
    drive(8'h20, P_TGT, 8'h00, 1'b1);
    drive(8'h08, P_COND, 8'h00, 1'b1);
    drive(8'h00, 8'h00, 8'h00, 1'b1);
    drive(8'h00, 8'h00, 8'h00, 1'b1);
    chk("t5_taken", 32'(o_taken), 32'h1);
    chk("t5_pc_load", 32'(o_pc), 32'h20);
    drive(8'h00, 8'h00, 8'h00, 1'b1);
    chk("t5_pc_hold", 32'(o_pc), 32'h20);

    // reset in the first flush cycle
    do_reset();
    drive(8'h55, P_TGT, 8'h00, 1'b0);
    drive(8'h08, P_COND, 8'h00, 1'b0);
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    chk("t6_flush_pre", 32'(o_flush), 32'h1);
    chk("t6_pc_pre", 32'(o_pc), 32'h55);
    #2 rst = 1'b1;
    #1;
    chk("t6_flush_rst", 32'(o_flush), 32'h0);
    chk("t6_pc_rst", 32'(o_pc), 32'h0);
    chk("t6_taken_rst", 32'(o_taken), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(8'h00, P_STAT, 8'h00, 1'b0);
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    chk("t6_status", 32'(o_data), 32'h00);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d, p, c;
      int unsigned sel;
      d = 8'($urandom);
      sel = $urandom_range(0, 9);
      p = (sel < 2) ? P_TGT : (sel < 5) ? P_COND : (sel < 7) ? P_STAT : 8'($urandom);
      sel = $urandom_range(0, 9);
      c = (sel < 4) ? 8'h00 : (sel < 9) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      drive(d, p, c, ($urandom_range(0, 3) == 0));
      rst = ($urandom_range(0, 199) == 0);
    end
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    repeat (3) drive(8'h00, 8'h00, 8'h00, 1'b0);

    run_check = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
